// File: rtl/regfile_if.sv
// Controller-side bus of the register file: shared address, read/write
// enables, registered read data with valid, and the four exported taps.
interface regfile_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic              i_en_r;
  logic              i_en_w;
  logic [WIDTH-1:0]  i_data;
  logic [ADDR_W-1:0] i_add;
  logic [WIDTH-1:0]  o_data;
  logic              o_vaild;
  logic [WIDTH-1:0]  o_reg_0;
  logic [WIDTH-1:0]  o_reg_1;
  logic [WIDTH-1:0]  o_reg_2;
  logic [WIDTH-1:0]  o_reg_3;

  modport master (
    output i_en_r, i_en_w, i_data, i_add,
    input  o_data, o_vaild, o_reg_0, o_reg_1, o_reg_2, o_reg_3
  );

  modport slave (
    input  i_en_r, i_en_w, i_data, i_add,
    output o_data, o_vaild, o_reg_0, o_reg_1, o_reg_2, o_reg_3
  );
endinterface

// File: rtl/regfile.sv
// Configuration/scratch register file: one shared-address port, write wins
// over read, 1-cycle registered read with valid, registers 0..3 tapped out.
module regfile #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  regfile_if.slave  bus
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [WIDTH-1:0]            r_data;
  logic                        r_vld;
  logic                        w_rd_acc;

  // A read colliding with a write is dropped, so no bypass path is needed.
  assign w_rd_acc = bus.i_en_r & ~bus.i_en_w;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mem  <= '0;
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_rd_acc;
      if (bus.i_en_w)
        r_mem[bus.i_add] <= bus.i_data;
      if (w_rd_acc)
        r_data <= r_mem[bus.i_add];
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_vaild = r_vld;
  assign bus.o_reg_0 = r_mem[0];
  assign bus.o_reg_1 = r_mem[1];
  assign bus.o_reg_2 = r_mem[2];
  assign bus.o_reg_3 = r_mem[3];
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, taps, collision,
// async reset mid-operation, then a random write/read sweep against a model.
module tb_regfile;
  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;
  logic [7:0] ref_mem [16];

  regfile_if #(.WIDTH(8), .ADDR_W(4)) bus ();

  regfile #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u_dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.i_en_w = 1'b1; bus.i_en_r = 1'b0; bus.i_add = a; bus.i_data = d;
    tick();
    bus.i_en_w = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.i_en_r = 1'b1; bus.i_en_w = 1'b0; bus.i_add = a;
    tick();
    bus.i_en_r = 1'b0;
  endtask

  task automatic chk_taps(input string tag, input logic [7:0] t0, t1, t2, t3);
    chk({tag, "_reg0"}, bus.o_reg_0, t0);
    chk({tag, "_reg1"}, bus.o_reg_1, t1);
    chk({tag, "_reg2"}, bus.o_reg_2, t2);
    chk({tag, "_reg3"}, bus.o_reg_3, t3);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] d;
    checks = 0;
    errors = 0;
    bus.i_en_r = 1'b0; bus.i_en_w = 1'b0; bus.i_data = '0; bus.i_add = '0;
    i_rst = 1'b1;

    // reset asserted mid-cycle, reads requested while held low
    #3 i_rst = 1'b0;
    #1;
    chk("rst_data", bus.o_data, 8'h00);
    chk("rst_vld", 8'(bus.o_vaild), 8'h00);
    chk_taps("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      bus.i_en_r = 1'b1; bus.i_add = 4'(i);
      tick();
      chk("rst_held_vld", 8'(bus.o_vaild), 8'h00);
    end
    bus.i_en_r = 1'b0;
    #2 i_rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("rst_rd_data", bus.o_data, 8'h00);
      chk("rst_rd_vld", 8'(bus.o_vaild), 8'h01);
    end

    // write then read, valid drops when read is released
    wr(4'd5, 8'hA5);
    chk("wr_vld", 8'(bus.o_vaild), 8'h00);
    rd(4'd5);
    chk("rd5_data", bus.o_data, 8'hA5);
    chk("rd5_vld", 8'(bus.o_vaild), 8'h01);
    tick();
    chk("idle_vld", 8'(bus.o_vaild), 8'h00);
    chk("idle_data", bus.o_data, 8'hA5);

    // taps follow writes with no extra latency
    wr(4'd0, 8'h11); chk_taps("tap0", 8'h11, 8'h00, 8'h00, 8'h00);
    wr(4'd1, 8'h22); chk_taps("tap1", 8'h11, 8'h22, 8'h00, 8'h00);
    wr(4'd2, 8'h33); chk_taps("tap2", 8'h11, 8'h22, 8'h33, 8'h00);
    wr(4'd3, 8'h44); chk_taps("tap3", 8'h11, 8'h22, 8'h33, 8'h44);
    wr(4'd4, 8'h55); chk_taps("tap4", 8'h11, 8'h22, 8'h33, 8'h44);
    rd(4'd4);
    chk("rd4_data", bus.o_data, 8'h55);
    rd(4'd2);
    chk("rd2_data", bus.o_data, 8'h33);

    // collision: write wins, read dropped, o_data holds
    bus.i_en_r = 1'b1; bus.i_en_w = 1'b1; bus.i_add = 4'd7; bus.i_data = 8'h3C;
    tick();
    bus.i_en_r = 1'b0; bus.i_en_w = 1'b0;
    chk("col_vld", 8'(bus.o_vaild), 8'h00);
    chk("col_data", bus.o_data, 8'h33);
    rd(4'd7);
    chk("col_rd_data", bus.o_data, 8'h3C);
    chk("col_rd_vld", 8'(bus.o_vaild), 8'h01);

    // async reset between edges clears everything at once
    wr(4'd15, 8'hFF);
    rd(4'd15);
    chk("rd15_data", bus.o_data, 8'hFF);
    chk("rd15_vld", 8'(bus.o_vaild), 8'h01);
    #2 i_rst = 1'b0;
    #1;
    chk("arst_data", bus.o_data, 8'h00);
    chk("arst_vld", 8'(bus.o_vaild), 8'h00);
    chk_taps("arst", 8'h00, 8'h00, 8'h00, 8'h00);
    #1 i_rst = 1'b1;
    rd(4'd15);
    chk("arst_rd15", bus.o_data, 8'h00);
    rd(4'd7);
    chk("arst_rd7", bus.o_data, 8'h00);

    // random write/read sweep against a reference array
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      a = 4'($urandom_range(15));
      d = 8'($urandom_range(255));
      wr(a, d);
      ref_mem[a] = d;
      a = 4'($urandom_range(15));
      rd(a);
      chk("rand_rd", bus.o_data, ref_mem[a]);
    end
    chk_taps("rand", ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
Synchronous register file, the system configuration/scratch storage of the UART-driven processing unit. The controller writes and reads words by address. A registered read port returns data with a valid flag. The first four registers are also exported continuously as dedicated outputs, for operand/configuration use by the ALU and UART blocks.

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 16, number of registers (REG_FILE_SIZE).
ADDR_W, 4, address width (REG_FILE_ADD_SIZE); DEPTH == 2**ADDR_W.

Ports:
i_clk  in  1  system clock; all state changes on rising edge.
i_rst  in  1  asynchronous, active-low reset.
i_en_r  in  1  read enable.
i_en_w  in  1  write enable.
i_data  in  WIDTH  write data.
i_add  in  ADDR_W  read/write address (shared).
o_data  out  WIDTH  registered read data.
o_vaild  out  1  read-data valid strobe (port name spelled exactly so).
o_reg_0  out  WIDTH  continuous copy of register 0.
o_reg_1  out  WIDTH  continuous copy of register 1.
o_reg_2  out  WIDTH  continuous copy of register 2.
o_reg_3  out  WIDTH  continuous copy of register 3.

Behaviour:
- One clock (i_clk); reset is asynchronous and active-low (i_rst). Asserting i_rst low immediately clears state, independent of the clock.
- Reset values: all DEPTH registers = 0; o_data = 0; o_vaild = 0; o_reg_0..3 = 0.
- Reset mid-operation aborts any pending write or read; no partial update survives.
- Write: on a rising edge with i_en_w=1, reg[i_add] <= i_data.
  - The new value is visible on o_reg_n (if n<4) right after that edge.
  - The new value is readable from the next cycle on.
- Read: on a rising edge with i_en_r=1 and i_en_w=0:
  - o_data <= reg[i_add];
  - o_vaild <= 1.
  - Latency is 1 cycle: data and valid appear after the edge that samples the request.
- o_vaild is high for exactly one cycle per accepted read. Back-to-back reads (i_en_r held high, i_en_w low) give o_vaild high continuously, with o_data updated every cycle.
- Any edge without an accepted read: o_vaild <= 0; o_data holds its last value (not cleared).
- Simultaneous i_en_r=1 and i_en_w=1: the write takes priority and is performed. The read is ignored (o_vaild <= 0, o_data unchanged).
- Address is full-range (DEPTH = 2**ADDR_W), so there is no out-of-range case. Every address is readable and writable.
- No write-through/bypass: a read sampled on the same edge as a write is not accepted, so stale data cannot occur.
- o_reg_0..3 are combinational taps of the storage, with no extra latency.

Test Plan:
- Reset: drive i_rst low mid-cycle, then read addresses 0..15 -> every o_data = 0x00; o_vaild=0 while i_rst low; o_reg_0..3 = 0x00.
- Write then read: write 0xA5 to addr 5 (1 cycle), then i_en_r=1, addr 5 -> one cycle later o_data=0xA5, o_vaild=1; with i_en_r dropped, the next cycle gives o_vaild=0 and o_data still 0xA5.
- Taps: write 0x11,0x22,0x33,0x44 to addrs 0..3 -> o_reg_0..3 show 0x11..0x44 after each write edge; a write of 0x55 to addr 4 does not disturb the taps.
- Collision: i_en_r=1 and i_en_w=1, addr 7, data 0x3C -> o_vaild=0 and o_data unchanged; a following read of addr 7 returns 0x3C.
- Async reset mid-operation: write 0xFF to addr 15, read it, pulse i_rst low between clock edges -> o_data, o_vaild and reg 15 clear immediately; a subsequent read of addr 15 returns 0x00.
- Random: 10000 iterations of a random write (data, addr) followed by a random read, compared against a reference array -> zero mismatches.
